// File: rtl/shift_register_engine.sv
// shift_register_engine
// Full-duplex serial shift engine. A transmit word is loaded in parallel and
// shifted out one bit per i_shift_en tick, MSB- or LSB-first. The bits
// clocked in on i_serial_in form a receive word, which is presented on a
// valid/ready handshake.
module shift_register_engine #(
  parameter int WORD_SIZE = 8,
  parameter int CNT_WIDTH = $clog2(WORD_SIZE) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load_valid,
  output logic                 o_load_ready,
  input  logic [WORD_SIZE-1:0] i_load_data,
  input  logic                 i_lsb_first,
  input  logic                 i_shift_en,
  input  logic                 i_serial_in,
  output logic                 o_serial_out,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic [WORD_SIZE-1:0] o_rx_data,
  output logic                 o_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Value r_count holds just before the tick that completes a word.
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(WORD_SIZE - 1);

  logic [1:0]           state;
  logic [WORD_SIZE-1:0] r_shift;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_lsb_first;

  logic [WORD_SIZE-1:0] shift_next;
  logic                 tx_next;
  logic                 load_first_bit;
  logic                 load_fire;
  logic                 last_tick;

  // A load is accepted only while idle. No word is queued during the
  // receive handshake.
  assign o_load_ready = (state == ST_IDLE);
  assign load_fire    = i_load_valid && o_load_ready;

  // The first transmit bit appears at the load edge, so the far end can
  // sample it on the first tick.
  assign load_first_bit = i_lsb_first ? i_load_data[0] : i_load_data[WORD_SIZE-1];

  // Each tick presents the bit next to the one that is leaving. This uses the
  // direction captured at load.
  assign tx_next = r_lsb_first ? r_shift[1] : r_shift[WORD_SIZE-2];

  assign last_tick = i_shift_en && (r_count == LAST_COUNT);

  // Shift register contents after one tick: receive bit enters at the end
  // opposite the transmit end.
  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    shift_next = r_shift;
    if (r_lsb_first) begin
      shift_next = {i_serial_in, r_shift[WORD_SIZE-1:1]};
    end else begin
      shift_next = {r_shift[WORD_SIZE-2:0], i_serial_in};
    end
  end

  // Sequencer: load, tick-driven shifting, and holding the receive word
  // until it is accepted.
  // NOTE: all state uses non-blocking assignments. Every right-hand side
  // therefore reads the pre-edge value, which makes the shift and the
  // transmit-bit update mutually consistent.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      r_shift      <= '0;
      r_count      <= '0;
      r_lsb_first  <= 1'b0;
      o_serial_out <= 1'b0;
      o_rx_valid   <= 1'b0;
      o_rx_data    <= '0;
      o_busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_fire) begin
            r_shift      <= i_load_data;
            r_lsb_first  <= i_lsb_first;
            r_count      <= '0;
            o_serial_out <= load_first_bit;
            o_busy       <= 1'b1;
            state        <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (i_shift_en) begin
            r_shift <= shift_next;
            r_count <= r_count + 1'b1;
            if (last_tick) begin
              o_rx_data    <= shift_next;
              o_rx_valid   <= 1'b1;
              o_serial_out <= 1'b0;
              o_busy       <= 1'b0;
              state        <= ST_DONE;
            end else begin
              o_serial_out <= tx_next;
            end
          end
        end

        ST_DONE: begin
          if (i_rx_ready) begin
            o_rx_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
